// File: rtl/psel_gen_sync_pkg.sv
// Shared constants for the multi-grant priority selector.
// Rows alternate between MSB-first and LSB-first picks.
package psel_gen_sync_pkg;

    localparam bit DIR_MSB = 1'b0;
    localparam bit DIR_LSB = 1'b1;

    function automatic bit row_dir(input int k);
        return (k % 2 == 1) ? DIR_LSB : DIR_MSB;
    endfunction

endpackage

// File: rtl/psel_gen_sync_onehot_prio_enc.sv
// One-hot priority pick of a single set bit.
// DIR selects whether the highest or lowest index wins.
module onehot_prio_enc
    import psel_gen_sync_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter bit DIR   = DIR_MSB
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] gnt
);

    // Later loop iterations overwrite earlier ones, so the scan
    // order decides which end wins.
    always_comb begin
        gnt = '0;
        if (DIR == DIR_MSB) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (req[i]) begin
                    gnt    = '0;
                    gnt[i] = 1'b1;
                end
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (req[i]) begin
                    gnt    = '0;
                    gnt[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/psel_gen_sync.sv
// Multi-grant selector: up to REQS grants, alternating ends,
// with a registered copy of the merged grant.
module psel_gen_sync
    import psel_gen_sync_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int REQS  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      req,
    output logic [WIDTH-1:0]      gnt,
    output logic [REQS*WIDTH-1:0] gnt_bus,
    output logic                  empty,
    output logic [WIDTH-1:0]      gnt_q
);

    // taken[k] holds every bit granted by rows 0..k-1
    logic [WIDTH-1:0] taken [REQS+1];
    logic [WIDTH-1:0] avail [REQS];

    assign taken[0] = '0;

    for (genvar k = 0; k < REQS; k++) begin : g_row
        assign avail[k] = req & ~taken[k];

        onehot_prio_enc #(
            .WIDTH (WIDTH),
            .DIR   (row_dir(k))
        ) u_enc (
            .req (avail[k]),
            .gnt (gnt_bus[k*WIDTH +: WIDTH])
        );

        assign taken[k+1] = taken[k] | gnt_bus[k*WIDTH +: WIDTH];
    end

    assign gnt   = taken[REQS];
    assign empty = ~|req;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt_q <= '0;
        end else begin
            gnt_q <= gnt;
        end
    end

endmodule

// File: tb/tb_psel_gen_sync.sv
// Scoreboard bench for psel_gen_sync: WIDTH=8 with REQS 1..4,
// plus a WIDTH=1 corner instance.
module tb_psel_gen_sync;

    typedef struct packed {
        logic [7:0]       r;
        logic             r1;
        logic [3:0][31:0] bus;
    } item_t;

    logic clk;
    logic reset;
    logic [7:0] req8;
    logic req1;

    logic [7:0]  gnt_a [4];
    logic [7:0]  gq_a  [4];
    logic        emp_a [4];
    logic [31:0] bus_a [4];

    logic [7:0]  b0;
    logic [15:0] b1;
    logic [23:0] b2;
    logic [31:0] b3;

    logic       w1_gnt, w1_emp, w1_gq;
    logic [1:0] w1_bus;

    item_t sbq[$];
    logic [7:0] cur_exp [4];
    logic       cur_exp1;
    logic [7:0] qm [4];
    logic       qm1;

    int errs   = 0;
    int checks = 0;

    psel_gen_sync #(.WIDTH(8), .REQS(1)) u_r1 (
        .clock(clk), .reset(reset), .req(req8), .gnt(gnt_a[0]),
        .gnt_bus(b0), .empty(emp_a[0]), .gnt_q(gq_a[0]));
    psel_gen_sync #(.WIDTH(8), .REQS(2)) u_r2 (
        .clock(clk), .reset(reset), .req(req8), .gnt(gnt_a[1]),
        .gnt_bus(b1), .empty(emp_a[1]), .gnt_q(gq_a[1]));
    psel_gen_sync #(.WIDTH(8), .REQS(3)) u_r3 (
        .clock(clk), .reset(reset), .req(req8), .gnt(gnt_a[2]),
        .gnt_bus(b2), .empty(emp_a[2]), .gnt_q(gq_a[2]));
    psel_gen_sync #(.WIDTH(8), .REQS(4)) u_r4 (
        .clock(clk), .reset(reset), .req(req8), .gnt(gnt_a[3]),
        .gnt_bus(b3), .empty(emp_a[3]), .gnt_q(gq_a[3]));
    psel_gen_sync #(.WIDTH(1), .REQS(2)) u_w1 (
        .clock(clk), .reset(reset), .req(req1), .gnt(w1_gnt),
        .gnt_bus(w1_bus), .empty(w1_emp), .gnt_q(w1_gq));

    assign bus_a[0] = {24'b0, b0};
    assign bus_a[1] = {16'b0, b1};
    assign bus_a[2] = {8'b0, b2};
    assign bus_a[3] = b3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Remaining requesters as a sorted list; even rows take the
    // largest index, odd rows take the smallest.
    function automatic logic [31:0] model(input logic [7:0] r,
                                          input int nreq);
        int idx[$];
        int pos;
        logic [31:0] bus = '0;
        for (int i = 0; i < 8; i++) if (r[i]) idx.push_back(i);
        for (int k = 0; k < nreq; k++) begin
            if (idx.size() == 0) break;
            pos = (k % 2 == 0) ? idx.pop_back() : idx.pop_front();
            bus[k*8 + pos] = 1'b1;
        end
        return bus;
    endfunction

    function automatic logic [7:0] merge(input logic [31:0] bus);
        return bus[7:0] | bus[15:8] | bus[23:16] | bus[31:24];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) qm[i] <= '0;
            qm1 <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) qm[i] <= cur_exp[i];
            qm1 <= cur_exp1;
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) cur_exp[i] = '0;
        cur_exp1 = 1'b0;
    end

    always @(negedge clk) begin
        item_t it;
        int pc, sum;
        if (sbq.size() > 0) begin
            it = sbq.pop_front();
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("bus%0d", i + 1), bus_a[i], it.bus[i]);
                chk($sformatf("gnt%0d", i + 1), {24'b0, gnt_a[i]},
                    {24'b0, merge(it.bus[i])});
                chk($sformatf("empty%0d", i + 1), {31'b0, emp_a[i]},
                    {31'b0, it.r == 8'h00});
                chk($sformatf("gnt_q%0d", i + 1), {24'b0, gq_a[i]},
                    {24'b0, qm[i]});
                pc  = $countones(it.r);
                sum = $countones(bus_a[i]);
                chk($sformatf("prop%0d", i + 1),
                    {31'b0, ($countones(gnt_a[i]) == ((pc < i + 1) ? pc : i + 1))
                     && ((gnt_a[i] & ~it.r) == 8'h00)
                     && (sum == $countones(gnt_a[i]))},
                    32'd1);
                cur_exp[i] = merge(it.bus[i]);
            end
            chk("w1_bus", {30'b0, w1_bus}, {31'b0, it.r1});
            chk("w1_gnt", {31'b0, w1_gnt}, {31'b0, it.r1});
            chk("w1_empty", {31'b0, w1_emp}, {31'b0, ~it.r1});
            chk("w1_gnt_q", {31'b0, w1_gq}, {31'b0, qm1});
            cur_exp1 = it.r1;
        end
    end

    task automatic apply(input logic [7:0] r, input logic r1);
        item_t it;
        @(posedge clk);
        #1;
        req8 = r;
        req1 = r1;
        it.r  = r;
        it.r1 = r1;
        for (int i = 0; i < 4; i++) it.bus[i] = model(r, i + 1);
        sbq.push_back(it);
    endtask

    initial begin
        reset = 1'b0;
        req8  = 8'h00;
        req1  = 1'b0;
        #1;
        chk("reset_q1", {24'b0, gq_a[0]}, 32'd0);
        chk("reset_q4", {24'b0, gq_a[3]}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        apply(8'b0010_1100, 1'b1);
        apply(8'h00, 1'b0);
        apply(8'hFF, 1'b1);
        apply(8'b0001_0100, 1'b0);
        apply(8'h01, 1'b1);
        apply(8'h80, 1'b1);
        apply(8'h80, 1'b1);
        #2;
        chk("pre_rst_q", {24'b0, gq_a[0]}, 32'h80);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++)
            chk($sformatf("async_clr%0d", i + 1), {24'b0, gq_a[i]}, 32'd0);
        chk("async_clr_w1", {31'b0, w1_gq}, 32'd0);
        chk("comb_in_rst", {24'b0, gnt_a[0]}, 32'h80);
        apply(8'h3C, 1'b0);
        apply(8'hA5, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int n = 0; n < 10000; n++)
            apply(8'($urandom), 1'($urandom));

        for (int t = 0; t < 10 && sbq.size() > 0; t++) @(posedge clk);
        chk("drain", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
